// File: rtl/mips_fetch_if.sv
// Instruction-memory read port of the MIPS fetch unit: a request/address pair
// toward memory and a ready/data pair coming back.
interface mips_fetch_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic [31:0] imem_data_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ready_in,
    input  imem_data_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ready_in,
    output imem_data_in
  );
endinterface

// File: rtl/mips_fetch.sv
// Multi-cycle MIPS fetch unit: FETCH waits on instruction memory, EXEC holds the
// latched instruction until it retires and the next PC is selected.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  mips_fetch_if.master       imem,
  output logic [5:0]         op_out,
  output logic [5:0]         func_out,
  output logic [31:0]        instr_out,
  output logic               instr_valid_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4_out,
  input  logic               branch_in,
  input  logic               bne_in,
  input  logic               jump_in,
  input  logic               jr_in,
  input  logic               zero_in,
  input  logic [31:0]        jr_target_in,
  input  logic               stall_in,
  output logic [31:0]        retired_count_out,
  output logic               misalign_out
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        retire;
  logic        taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  assign accept = (state == FETCH) && imem.imem_ready_in;
  assign retire = (state == EXEC) && !stall_in;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem.imem_ready_in) state_next = EXEC;
      EXEC:    if (!stall_in)          state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Output logic: the request is suppressed during reset so a pending fetch
  // is abandoned immediately rather than one cycle later.
  always_comb begin
    imem.imem_req_out  = (state == FETCH) && !reset;
    imem.imem_addr_out = pc_out;
  end

  assign op_out       = instr_out[31:26];
  assign func_out     = instr_out[5:0];
  assign pc_plus4_out = pc_out + 32'd4;

  assign taken         = (branch_in && zero_in) || (bne_in && !zero_in);
  assign branch_target = pc_plus4_out + {{14{instr_out[15]}}, instr_out[15:0], 2'b00};
  assign jump_target   = {pc_plus4_out[31:28], instr_out[25:0], 2'b00};

  // jr wins over jump, jump over a taken branch.
  always_comb begin
    next_pc = pc_plus4_out;
    if (jr_in)        next_pc = {jr_target_in[31:2], 2'b00};
    else if (jump_in) next_pc = jump_target;
    else if (taken)   next_pc = branch_target;
  end

  // Architectural registers; control inputs only matter in a retiring cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out            <= RESET_PC;
      instr_out         <= 32'd0;
      instr_valid_out   <= 1'b0;
      retired_count_out <= 32'd0;
      misalign_out      <= 1'b0;
    end else begin
      if (accept) begin
        instr_out       <= imem.imem_data_in;
        instr_valid_out <= 1'b1;
      end
      if (retire) begin
        pc_out            <= next_pc;
        instr_valid_out   <= 1'b0;
        retired_count_out <= retired_count_out + 32'd1;
        if (jr_in && (jr_target_in[1:0] != 2'b00)) misalign_out <= 1'b1;
      end
    end
  end

endmodule
